lsu: RTL and testbench



---
 rtl/lsu_pkg.sv | 50 +++++
 rtl/lsu_align.sv | 89 ++++++++
 rtl/lsu.sv | 222 ++++++++++++++++++++++
 tb/tb_lsu.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg
//   Shared definitions for the MEM-stage load/store unit: memory operation
//   codes, FSM state encoding, address-error exception codes, and small
//   helpers that classify an operation.
//   No ports (package).
package lsu_pkg;

  // Memory operation codes as presented by the EX stage (9-15 are illegal)
  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_LB   = 4'd1;
  localparam logic [3:0] OP_LBU  = 4'd2;
  localparam logic [3:0] OP_LH   = 4'd3;
  localparam logic [3:0] OP_LHU  = 4'd4;
  localparam logic [3:0] OP_LW   = 4'd5;
  localparam logic [3:0] OP_SB   = 4'd6;
  localparam logic [3:0] OP_SH   = 4'd7;
  localparam logic [3:0] OP_SW   = 4'd8;

  // Address-error exception codes (MIPS Cause.ExcCode values)
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_EXC  = 2'd3
  } lsuState_e;

  function automatic logic isLoad(input logic [3:0] op);
    return (op >= OP_LB) && (op <= OP_LW);
  endfunction

  function automatic logic isStore(input logic [3:0] op);
    return (op >= OP_SB) && (op <= OP_SW);
  endfunction

  // Halfwords need an even address, words need a 4-byte aligned address
  function automatic logic isMisaligned(input logic [3:0] op, input logic [1:0] off);
    logic result;
    result = 1'b0;
    case (op)
      OP_LH, OP_LHU, OP_SH: result = off[0];
      OP_LW, OP_SW:         result = (off != 2'b00);
      default:              result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align
//   Combinational byte-lane steering for the load/store unit.
//   Store side turns (op, offset, wdata) into byte enables and lane-replicated
//   write data; load side picks the addressed byte/halfword out of the
//   returned word and sign- or zero-extends it.
// Ports:
//   op_i        [3:0]  memory operation code
//   offset_i    [1:0]  byte offset within the word (addr[1:0])
//   wdata_i     [31:0] store source register value
//   rdata_i     [31:0] word returned by data memory
//   be_o        [3:0]  byte enables, lane k = bits [8k+7:8k]
//   wdataRep_o  [31:0] store data replicated across all lanes
//   loadData_o  [31:0] extended load result
module lsu_align import lsu_pkg::*; (
  input  logic [3:0]  op_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdataRep_o,
  output logic [31:0] loadData_o
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  // Pick the addressed byte and halfword lane out of the returned word.
  // Halfword accesses are known to be aligned here, so only offset bit 1
  // matters for the halfword lane.
  always_comb begin
    byteSel = rdata_i[7:0];
    case (offset_i)
      2'd0: byteSel = rdata_i[7:0];
      2'd1: byteSel = rdata_i[15:8];
      2'd2: byteSel = rdata_i[23:16];
      2'd3: byteSel = rdata_i[31:24];
      default: byteSel = rdata_i[7:0];
    endcase
    halfSel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  // Byte enables follow the access width for both loads and stores; store
  // data is replicated so memory can take it from whichever lanes are enabled.
  always_comb begin
    be_o       = 4'b0000;
    wdataRep_o = 32'h0000_0000;
    loadData_o = 32'h0000_0000;
    case (op_i)
      OP_LB: begin
        be_o       = 4'b0001 << offset_i;
        loadData_o = {{24{byteSel[7]}}, byteSel};
      end
      OP_LBU: begin
        be_o       = 4'b0001 << offset_i;
        loadData_o = {24'h00_0000, byteSel};
      end
      OP_LH: begin
        be_o       = 4'b0011 << offset_i;
        loadData_o = {{16{halfSel[15]}}, halfSel};
      end
      OP_LHU: begin
        be_o       = 4'b0011 << offset_i;
        loadData_o = {16'h0000, halfSel};
      end
      OP_LW: begin
        be_o       = 4'b1111;
        loadData_o = rdata_i;
      end
      OP_SB: begin
        be_o       = 4'b0001 << offset_i;
        wdataRep_o = {4{wdata_i[7:0]}};
      end
      OP_SH: begin
        be_o       = 4'b0011 << offset_i;
        wdataRep_o = {2{wdata_i[15:0]}};
      end
      OP_SW: begin
        be_o       = 4'b1111;
        wdataRep_o = wdata_i;
      end
      default: begin
        be_o       = 4'b0000;
        wdataRep_o = 32'h0000_0000;
        loadData_o = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: rtl/lsu.sv
// lsu
//   MEM-stage load/store unit. Accepts one operation at a time from EX,
//   issues a single outstanding request to data memory, aligns and extends
//   load data, and raises AdEL/AdES for misaligned halfword/word accesses.
//   A flush kills the current operation's response or exception, but a
//   request already on the bus always runs to its acknowledge.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   req_valid/req_ready             EX handshake (ready only when idle)
//   mem_op, addr, wdata, rd_idx     operation, byte address, store data, dest reg
//   flush                           cancel the in-flight operation's result
//   dm_req/dm_we/dm_be/dm_addr/
//   dm_wdata/dm_ack/dm_rdata        data memory request/acknowledge port
//   resp_valid/resp_we/resp_rd/
//   resp_data                       writeback response (registered pulse)
//   exc_valid/exc_code/badvaddr     address-error exception (registered pulse)
//   busy                            pipeline stall, high whenever not idle
module lsu import lsu_pkg::*; (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [4:0]  rd_idx,
  input  logic        flush,
  output logic        dm_req,
  output logic        dm_we,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        resp_valid,
  output logic        resp_we,
  output logic [4:0]  resp_rd,
  output logic [31:0] resp_data,
  output logic        exc_valid,
  output logic [4:0]  exc_code,
  output logic [31:0] badvaddr,
  output logic        busy
);

  lsuState_e   state_q, state_d;

  logic [3:0]  capOp_q, capOp_d;
  logic [31:0] capAddr_q, capAddr_d;
  logic [31:0] capWdata_q, capWdata_d;
  logic [4:0]  capRd_q, capRd_d;
  logic        kill_q, kill_d;

  logic        respValid_q, respValid_d;
  logic        respWe_q, respWe_d;
  logic [4:0]  respRd_q, respRd_d;
  logic [31:0] respData_q, respData_d;
  logic        excValid_q, excValid_d;
  logic [4:0]  excCode_q, excCode_d;
  logic [31:0] badVaddr_q, badVaddr_d;

  logic        accept;
  logic        opLegal;
  logic        opMisaligned;
  logic        killNow;
  logic [3:0]  alignBe;
  logic [31:0] alignWdata;
  logic [31:0] alignLoad;

  assign accept       = req_valid && req_ready;
  assign opLegal      = isLoad(mem_op) || isStore(mem_op);
  assign opMisaligned = isMisaligned(mem_op, addr[1:0]);
  assign killNow      = kill_q || flush;

  // Lane steering always works from the captured operation so the bus
  // outputs stay stable for the whole request even if EX changes its inputs.
  lsu_align uAlign (
    .op_i       (capOp_q),
    .offset_i   (capAddr_q[1:0]),
    .wdata_i    (capWdata_q),
    .rdata_i    (dm_rdata),
    .be_o       (alignBe),
    .wdataRep_o (alignWdata),
    .loadData_o (alignLoad)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. NONE and illegal codes are simply dropped in IDLE.
  // RESP and EXC each last exactly one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && opLegal) begin
          state_d = opMisaligned ? ST_EXC : ST_REQ;
        end
      end
      ST_REQ: begin
        if (dm_ack) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      ST_EXC:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State-derived outputs. The memory port is only driven while a request is
  // outstanding, so it reads all-zero at every other time including reset.
  always_comb begin
    req_ready = (state_q == ST_IDLE);
    busy      = (state_q != ST_IDLE);
    dm_req    = (state_q == ST_REQ);
    dm_we     = 1'b0;
    dm_be     = 4'b0000;
    dm_addr   = 32'h0000_0000;
    dm_wdata  = 32'h0000_0000;
    if (state_q == ST_REQ) begin
      dm_we    = isStore(capOp_q);
      dm_be    = alignBe;
      dm_addr  = {capAddr_q[31:2], 2'b00};
      dm_wdata = alignWdata;
    end
  end

  // Capture, kill and result computation. The response and exception are
  // registered: they are decided on the cycle that enters RESP/EXC, so the
  // kill check folds in a flush arriving on that same cycle. Result fields
  // are only rewritten when a pulse is actually delivered, so they hold
  // their last reported value otherwise.
  always_comb begin
    capOp_d     = capOp_q;
    capAddr_d   = capAddr_q;
    capWdata_d  = capWdata_q;
    capRd_d     = capRd_q;
    kill_d      = kill_q;
    respValid_d = 1'b0;
    respWe_d    = respWe_q;
    respRd_d    = respRd_q;
    respData_d  = respData_q;
    excValid_d  = 1'b0;
    excCode_d   = excCode_q;
    badVaddr_d  = badVaddr_q;
    case (state_q)
      ST_IDLE: begin
        kill_d = 1'b0;
        if (accept && opLegal) begin
          capOp_d    = mem_op;
          capAddr_d  = addr;
          capWdata_d = wdata;
          capRd_d    = rd_idx;
          kill_d     = flush;
          if (opMisaligned && !flush) begin
            excValid_d = 1'b1;
            excCode_d  = isStore(mem_op) ? EXC_ADES : EXC_ADEL;
            badVaddr_d = addr;
          end
        end
      end
      ST_REQ: begin
        kill_d = killNow;
        if (dm_ack && !killNow) begin
          respValid_d = 1'b1;
          respWe_d    = isLoad(capOp_q) && (capRd_q != 5'd0);
          respRd_d    = capRd_q;
          respData_d  = isLoad(capOp_q) ? alignLoad : 32'h0000_0000;
        end
      end
      default: begin
        kill_d = 1'b0;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      capOp_q     <= OP_NONE;
      capAddr_q   <= 32'h0000_0000;
      capWdata_q  <= 32'h0000_0000;
      capRd_q     <= 5'd0;
      kill_q      <= 1'b0;
      respValid_q <= 1'b0;
      respWe_q    <= 1'b0;
      respRd_q    <= 5'd0;
      respData_q  <= 32'h0000_0000;
      excValid_q  <= 1'b0;
      excCode_q   <= 5'd0;
      badVaddr_q  <= 32'h0000_0000;
    end else begin
      capOp_q     <= capOp_d;
      capAddr_q   <= capAddr_d;
      capWdata_q  <= capWdata_d;
      capRd_q     <= capRd_d;
      kill_q      <= kill_d;
      respValid_q <= respValid_d;
      respWe_q    <= respWe_d;
      respRd_q    <= respRd_d;
      respData_q  <= respData_d;
      excValid_q  <= excValid_d;
      excCode_q   <= excCode_d;
      badVaddr_q  <= badVaddr_d;
    end
  end

  assign resp_valid = respValid_q;
  assign resp_we    = respWe_q;
  assign resp_rd    = respRd_q;
  assign resp_data  = respData_q;
  assign exc_valid  = excValid_q;
  assign exc_code   = excCode_q;
  assign badvaddr   = badVaddr_q;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu
//   Self-checking bench for the load/store unit: directed cases followed by
//   randomized operations, compared against a byte-level reference model.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  mem_op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [4:0]  rd_idx;
  logic        flush;
  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        resp_valid;
  logic        resp_we;
  logic [4:0]  resp_rd;
  logic [31:0] resp_data;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] badvaddr;
  logic        busy;

  int compareCount  = 0;
  int mismatchCount = 0;

  // Last delivered result values; these must hold between pulses
  logic [31:0] lastRespData;
  logic [4:0]  lastRespRd;
  logic        lastRespWe;
  logic [4:0]  lastExcCode;
  logic [31:0] lastBadVaddr;

  always #5 clk = ~clk;

  lsu dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .mem_op     (mem_op),
    .addr       (addr),
    .wdata      (wdata),
    .rd_idx     (rd_idx),
    .flush      (flush),
    .dm_req     (dm_req),
    .dm_we      (dm_we),
    .dm_be      (dm_be),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_ack     (dm_ack),
    .dm_rdata   (dm_rdata),
    .resp_valid (resp_valid),
    .resp_we    (resp_we),
    .resp_rd    (resp_rd),
    .resp_data  (resp_data),
    .exc_valid  (exc_valid),
    .exc_code   (exc_code),
    .badvaddr   (badvaddr),
    .busy       (busy)
  );

  // Reference model: access width in bytes, 0 for NONE/illegal codes
  function automatic int opWidth(input logic [3:0] op);
    case (op)
      4'd1, 4'd2, 4'd6: return 1;
      4'd3, 4'd4, 4'd7: return 2;
      4'd5, 4'd8:       return 4;
      default:          return 0;
    endcase
  endfunction

  function automatic bit opIsStore(input logic [3:0] op);
    return (op >= 4'd6) && (op <= 4'd8);
  endfunction

  function automatic bit opIsLoad(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd5);
  endfunction

  function automatic bit modelMisaligned(input logic [3:0] op, input logic [1:0] off);
    return (int'(off) % opWidth(op)) != 0;
  endfunction

  // A mask of 'width' ones starting at the byte offset
  function automatic logic [3:0] modelBe(input logic [3:0] op, input logic [1:0] off);
    int w;
    w = opWidth(op);
    return 4'(((1 << w) - 1) << int'(off));
  endfunction

  // Each memory lane k carries store byte (k mod width)
  function automatic logic [31:0] modelStoreData(input logic [3:0] op, input logic [31:0] wd);
    logic [31:0] r;
    int w;
    w = opWidth(op);
    r = 32'h0;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = wd[8*(k % w) +: 8];
    return r;
  endfunction

  // Shift the addressed bytes down, trim to width, then sign-extend by
  // subtracting 2^(8*width) when the top bit is set for signed loads
  function automatic logic [31:0] modelLoad(input logic [3:0] op, input logic [1:0] off,
                                            input logic [31:0] rdata);
    logic [31:0] v;
    int w;
    w = opWidth(op);
    v = rdata >> (8 * int'(off));
    if (w == 1) begin
      v = v & 32'h0000_00FF;
      if ((op == 4'd1) && v[7]) v = v - 32'd256;
    end else if (w == 2) begin
      v = v & 32'h0000_FFFF;
      if ((op == 4'd3) && v[15]) v = v - 32'd65536;
    end
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    assert (observed === expected) else begin
      mismatchCount++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".dm_req"},     dm_req,     32'd0);
    checkOutput({tag, ".dm_we"},      dm_we,      32'd0);
    checkOutput({tag, ".dm_be"},      dm_be,      32'd0);
    checkOutput({tag, ".dm_addr"},    dm_addr,    32'd0);
    checkOutput({tag, ".dm_wdata"},   dm_wdata,   32'd0);
    checkOutput({tag, ".resp_valid"}, resp_valid, 32'd0);
    checkOutput({tag, ".resp_we"},    resp_we,    32'd0);
    checkOutput({tag, ".resp_rd"},    resp_rd,    32'd0);
    checkOutput({tag, ".resp_data"},  resp_data,  32'd0);
    checkOutput({tag, ".exc_valid"},  exc_valid,  32'd0);
    checkOutput({tag, ".exc_code"},   exc_code,   32'd0);
    checkOutput({tag, ".badvaddr"},   badvaddr,   32'd0);
    checkOutput({tag, ".busy"},       busy,       32'd0);
  endtask

  // Runs one operation cycle by cycle from the accept cycle until the unit
  // is ready again. flushAt: -1 none, 0 with acceptance, k>=1 in request
  // cycle k. ackDelay is the number of request cycles without ack.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] wd, input logic [4:0] rd,
                               input logic [31:0] rdata, input int ackDelay,
                               input int flushAt);
    bit killed;
    checkOutput("readyAtAccept", req_ready, 32'd1);
    req_valid = 1'b1;
    mem_op    = op;
    addr      = a;
    wdata     = wd;
    rd_idx    = rd;
    flush     = (flushAt == 0);
    @(negedge clk);
    req_valid = 1'b0;
    flush     = 1'b0;
    mem_op    = 4'($urandom);
    addr      = $urandom;
    wdata     = $urandom;
    rd_idx    = 5'($urandom);

    if (opWidth(op) == 0) begin
      checkOutput("discardReady", req_ready, 32'd1);
      checkOutput("discardReq",   dm_req,    32'd0);
      checkOutput("discardBusy",  busy,      32'd0);
      return;
    end

    killed = (flushAt == 0);
    if (modelMisaligned(op, a[1:0])) begin
      if (!killed) begin
        lastExcCode  = opIsStore(op) ? 5'd5 : 5'd4;
        lastBadVaddr = a;
      end
      checkOutput("excValid",  exc_valid, {31'd0, !killed});
      checkOutput("excCode",   exc_code,  lastExcCode);
      checkOutput("badvaddr",  badvaddr,  lastBadVaddr);
      checkOutput("excNoReq",  dm_req,    32'd0);
      checkOutput("excBusy",   busy,      32'd1);
      checkOutput("excReady",  req_ready, 32'd0);
      @(negedge clk);
      checkOutput("excPulse",  exc_valid, 32'd0);
      checkOutput("excReady2", req_ready, 32'd1);
      checkOutput("excNoReq2", dm_req,    32'd0);
      return;
    end

    for (int c = 1; c <= ackDelay + 1; c++) begin
      checkOutput("dmReq",  dm_req,  32'd1);
      checkOutput("dmWe",   dm_we,   {31'd0, opIsStore(op)});
      checkOutput("dmBe",   dm_be,   modelBe(op, a[1:0]));
      checkOutput("dmAddr", dm_addr, {a[31:2], 2'b00});
      if (opIsStore(op)) checkOutput("dmWdata", dm_wdata, modelStoreData(op, wd));
      checkOutput("reqNoResp", resp_valid, 32'd0);
      checkOutput("reqBusy",   busy,       32'd1);
      if (flushAt == c) killed = 1'b1;
      flush    = (flushAt == c);
      dm_ack   = (c == ackDelay + 1);
      dm_rdata = dm_ack ? rdata : $urandom;
      @(negedge clk);
    end
    dm_ack = 1'b0;
    flush  = 1'b0;

    if (!killed) begin
      lastRespWe   = opIsLoad(op) && (rd != 5'd0);
      lastRespRd   = rd;
      lastRespData = opIsLoad(op) ? modelLoad(op, a[1:0], rdata) : 32'h0;
    end
    checkOutput("respValid", resp_valid, {31'd0, !killed});
    checkOutput("respWe",    resp_we,    {31'd0, lastRespWe});
    checkOutput("respRd",    resp_rd,    {27'd0, lastRespRd});
    checkOutput("respData",  resp_data,  lastRespData);
    checkOutput("respNoReq", dm_req,     32'd0);
    checkOutput("respReady", req_ready,  32'd0);
    @(negedge clk);
    checkOutput("idleReady", req_ready,  32'd1);
    checkOutput("respPulse", resp_valid, 32'd0);
    checkOutput("respHold",  resp_data,  lastRespData);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    mem_op    = 4'd0;
    addr      = 32'h0;
    wdata     = 32'h0;
    rd_idx    = 5'd0;
    flush     = 1'b0;
    dm_ack    = 1'b0;
    dm_rdata  = 32'h0;
    lastRespData = 32'h0;
    lastRespRd   = 5'd0;
    lastRespWe   = 1'b0;
    lastExcCode  = 5'd0;
    lastBadVaddr = 32'h0;

    // Reset state
    repeat (2) @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("readyAfterReset", req_ready, 32'd1);

    // Loads: word, signed/unsigned byte, signed halfword
    applyStimulus(4'd5, 32'h0000_0100, 32'h0, 5'd5, 32'hDEAD_BEEF, 0, -1);
    checkOutput("lwData", resp_data, 32'hDEAD_BEEF);
    checkOutput("lwWe",   resp_we,   32'd1);
    applyStimulus(4'd1, 32'h0000_0103, 32'h0, 5'd7, 32'h80FF_0000, 1, -1);
    checkOutput("lbData", resp_data, 32'hFFFF_FF80);
    applyStimulus(4'd2, 32'h0000_0103, 32'h0, 5'd7, 32'h80FF_0000, 0, -1);
    checkOutput("lbuData", resp_data, 32'h0000_0080);
    applyStimulus(4'd3, 32'h0000_0102, 32'h0, 5'd9, 32'h80FF_0000, 2, -1);
    checkOutput("lhData", resp_data, 32'hFFFF_80FF);

    // Stores: byte and halfword lane replication (bus checked inside)
    applyStimulus(4'd6, 32'h0000_0202, 32'h1234_5678, 5'd1, 32'h0, 0, -1);
    applyStimulus(4'd7, 32'h0000_0202, 32'h1234_5678, 5'd1, 32'h0, 0, -1);
    checkOutput("storeRespData", resp_data, 32'h0);

    // Misaligned word load and halfword store
    applyStimulus(4'd5, 32'h0000_0101, 32'h0, 5'd3, 32'h0, 0, -1);
    checkOutput("adelCode", exc_code, 32'd4);
    checkOutput("adelAddr", badvaddr, 32'h0000_0101);
    applyStimulus(4'd7, 32'h0000_0003, 32'h0, 5'd3, 32'h0, 0, -1);
    checkOutput("adesCode", exc_code, 32'd5);

    // Slow ack with flush in the second request cycle: no response
    applyStimulus(4'd5, 32'h0000_0400, 32'h0, 5'd4, 32'h1111_2222, 5, 2);

    // Flush while idle must not kill the next operation
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    applyStimulus(4'd4, 32'h0000_0502, 32'h0, 5'd6, 32'hABCD_1234, 0, -1);
    checkOutput("lhuAfterIdleFlush", resp_data, 32'h0000_ABCD);

    // Flushed misaligned access raises nothing
    applyStimulus(4'd8, 32'h0000_0602, 32'h0, 5'd2, 32'h0, 0, 0);

    // Reset in the middle of a request
    req_valid = 1'b1;
    mem_op    = 4'd5;
    addr      = 32'h0000_0700;
    rd_idx    = 5'd8;
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("midReqActive", dm_req, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    checkAllZero("midReqReset");
    rst_n = 1'b1;
    lastRespData = 32'h0;
    lastRespRd   = 5'd0;
    lastRespWe   = 1'b0;
    lastExcCode  = 5'd0;
    lastBadVaddr = 32'h0;
    @(negedge clk);
    checkOutput("readyAfterMidReset", req_ready, 32'd1);

    // Load to r0 completes without a register write
    applyStimulus(4'd5, 32'h0000_0800, 32'h0, 5'd0, 32'h5555_AAAA, 0, -1);
    checkOutput("r0We", resp_we, 32'd0);

    // Randomized operations against the reference model
    for (int i = 0; i < 60; i++) begin
      logic [3:0]  op;
      logic [31:0] a;
      int          sel;
      int          w;
      int          delay;
      int          fAt;
      sel = $urandom_range(0, 19);
      if (sel < 17)       op = 4'($urandom_range(1, 8));
      else if (sel == 17) op = 4'd0;
      else                op = 4'($urandom_range(9, 15));
      w = opWidth(op);
      a = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (w == 2) a[0] = 1'b0;
        if (w == 4) a[1:0] = 2'b00;
      end
      delay = $urandom_range(0, 3);
      sel   = $urandom_range(0, 9);
      if (sel == 0)      fAt = 0;
      else if (sel == 1) fAt = $urandom_range(1, delay + 1);
      else               fAt = -1;
      if ($urandom_range(0, 3) == 0) begin
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("idleFlushReady", req_ready, 32'd1);
      end
      applyStimulus(op, a, $urandom, 5'($urandom), $urandom, delay, fAt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
